// File: rtl/branch_predictor.sv
// Dynamic branch predictor: saturating-counter pattern table (bimodal or
// gshare indexed) plus a tagged branch target buffer. Lookup is purely
// combinational from registered state; training comes from ID resolution.
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int HIST_EN  = 1,
    parameter int GHR_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    // fetch-side lookup
    input  logic [31:0]         pc,
    output logic                pred_taken,
    output logic                pred_hit,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    // ID-side training
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_pred_taken,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic                btb_inv,
    // statistics
    input  logic                stat_clr,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
    } btb_ent_t;

    // state
    logic [ENTRIES-1:0][CTR_BITS-1:0] pht_q, pht_d;
    logic [ENTRIES-1:0]               btb_vld_q, btb_vld_d;
    btb_ent_t                         btb_q [ENTRIES];
    logic [GHR_BITS-1:0]              ghr_q, ghr_d;
    logic [31:0]                      stat_br_q, stat_br_d;
    logic [31:0]                      stat_mp_q, stat_mp_d;

    // index/tag extraction
    logic [IDX-1:0]      lk_bidx, lk_pidx, up_bidx, up_pidx;
    logic [IDX-1:0]      ghr_ext, upd_ghr_ext;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic [CTR_BITS-1:0] lk_ctr, up_ctr;
    logic                mispredict;
    btb_ent_t            lk_ent, up_ent;

    assign lk_bidx = pc[IDX+1:2];
    assign up_bidx = upd_pc[IDX+1:2];
    assign lk_tag  = pc[IDX+2+TAG_BITS-1:IDX+2];
    assign up_tag  = upd_pc[IDX+2+TAG_BITS-1:IDX+2];

    // zero-extend the histories to index width (GHR_BITS may equal IDX)
    always_comb begin
        ghr_ext                      = '0;
        upd_ghr_ext                  = '0;
        ghr_ext[GHR_BITS-1:0]        = ghr_q;
        upd_ghr_ext[GHR_BITS-1:0]    = upd_ghr;
    end

    assign lk_pidx = (HIST_EN != 0) ? (lk_bidx ^ ghr_ext)     : lk_bidx;
    assign up_pidx = (HIST_EN != 0) ? (up_bidx ^ upd_ghr_ext) : up_bidx;

    // lookup path: no bypass, reads only registered state
    assign lk_ctr      = pht_q[lk_pidx];
    assign lk_ent      = btb_q[lk_bidx];
    assign pred_hit    = btb_vld_q[lk_bidx] && (lk_ent.tag == lk_tag);
    assign pred_taken  = pred_hit && lk_ctr[CTR_BITS-1];
    assign pred_target = pred_taken ? lk_ent.target : (pc + 32'd4);
    assign pred_ghr    = (HIST_EN != 0) ? ghr_q : '0;

    // mispredict uses the BTB target as it stands before this cycle's write
    assign up_ctr     = pht_q[up_pidx];
    assign up_ent     = btb_q[up_bidx];
    assign mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && (up_ent.target != upd_target));

    // next-state for counters, valid bits, history and statistics
    always_comb begin
        pht_d     = pht_q;
        btb_vld_d = btb_vld_q;
        ghr_d     = ghr_q;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_valid) begin
            if (upd_taken) begin
                if (up_ctr != CTR_MAX) pht_d[up_pidx] = up_ctr + CTR_BITS'(1);
                btb_vld_d[up_bidx] = 1'b1;
            end else if (up_ctr != '0) begin
                pht_d[up_pidx] = up_ctr - CTR_BITS'(1);
            end
            if (GHR_BITS == 1) ghr_d = GHR_BITS'(upd_taken);
            else               ghr_d = GHR_BITS'({ghr_q, upd_taken});
            if (stat_br_q != '1)               stat_br_d = stat_br_q + 32'd1;
            if (mispredict && stat_mp_q != '1) stat_mp_d = stat_mp_q + 32'd1;
        end
        // invalidate beats a same-cycle fill
        if (btb_inv) btb_vld_d = '0;
        if (stat_clr) begin
            stat_br_d = '0;
            stat_mp_d = '0;
        end
    end

    // resettable state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pht_q     <= {ENTRIES{CTR_INIT}};
            btb_vld_q <= '0;
            ghr_q     <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            pht_q     <= pht_d;
            btb_vld_q <= btb_vld_d;
            ghr_q     <= ghr_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    // BTB tag/target payload, written on taken resolution; not reset
    always_ff @(posedge CLK) begin
        if (upd_valid && upd_taken) begin
            btb_q[up_bidx] <= '{tag: up_tag, target: upd_target};
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage core: an N-entry saturating-counter pattern table with optional gshare history indexing, plus a tagged branch target buffer. It sits beside the IF stage, where it gives a same-cycle taken/target prediction for the fetch PC. It is trained from the ID-stage branch resolution. It also keeps saturating performance counters for resolved branches and mispredicts.

## Interface
- ENTRIES, 16: PHT and BTB depth; power of two, ≥4; IDX = log2(ENTRIES).
- CTR_BITS, 2: saturating counter width, 2..4.
- TAG_BITS, 8: BTB tag width, taken from PC[IDX+2+TAG_BITS-1 : IDX+2].
- HIST_EN, 1: 1 = gshare indexing, 0 = bimodal indexing.
- GHR_BITS, 4: global history length, 1..IDX; ignored when HIST_EN=0.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- pc  in  32  IF-stage fetch PC.
- pred_taken  out  1  predict taken; requires a BTB hit and counter MSB = 1.
- pred_hit  out  1  BTB entry valid and tag matches.
- pred_target  out  32  BTB target when pred_taken, else pc+4.
- pred_ghr  out  GHR_BITS  history snapshot; the pipeline carries it with the branch.
- upd_valid  in  1  conditional branch resolved in ID this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_ghr  in  GHR_BITS  pred_ghr captured when this branch was fetched.
- upd_pred_taken  in  1  prediction that was used for this branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  computed branch target (PC+imm).
- btb_inv  in  1  invalidate all BTB entries (fence.i).
- stat_clr  in  1  synchronous clear of the statistics counters.
- stat_branches  out  32  resolved branch count, saturating.
- stat_mispredicts  out  32  mispredict count, saturating.

## Operation
- **Index functions**
  - bidx(p) = p[IDX+1:2].
  - pidx(p,h) = bidx(p) XOR zero-extended h when HIST_EN=1, else bidx(p).
- **Lookup** (combinational, from registered state)
  - PHT counter read at pidx(pc, ghr).
  - BTB entry read at bidx(pc); pred_hit = valid && tag == pc tag bits.
  - pred_taken = pred_hit && counter[CTR_BITS-1].
  - pred_ghr = ghr. When HIST_EN=0, pred_ghr = 0.
- **Update** (on a clock edge with upd_valid=1)
  - PHT counter at pidx(upd_pc, upd_ghr): increment toward 2^CTR_BITS−1 if upd_taken, else decrement toward 0. It saturates at both ends and never wraps.
  - If upd_taken, write the BTB at bidx(upd_pc) with valid=1, tag of upd_pc, and upd_target. A not-taken outcome leaves the BTB unchanged.
  - ghr ← {ghr[GHR_BITS-2:0], upd_taken}. For GHR_BITS=1, ghr ← upd_taken.
  - A mispredict is (upd_pred_taken ≠ upd_taken), or (upd_taken && BTB target at bidx(upd_pc) ≠ upd_target before the write).
- **Invalidate**: btb_inv clears every valid bit in one cycle. If an update write happens in the same cycle, btb_inv wins and the entry ends invalid. PHT, GHR and statistics are unaffected.
- **Statistics**
  - stat_branches increments on upd_valid.
  - stat_mispredicts increments on upd_valid && mispredict.
  - Both saturate at 0xFFFFFFFF.
  - stat_clr forces both to 0 and takes priority over an increment in the same cycle.

## Timing
- **Reset** (RST=0, asynchronous):
  - every PHT counter = 2^(CTR_BITS−1)−1 (weakly not-taken; 01 for 2-bit);
  - all BTB valid bits = 0; ghr = 0; both statistics = 0.
  - Outputs during and after reset: pred_taken=0, pred_hit=0, pred_target=pc+4, pred_ghr=0.
- **Lookup latency**: zero cycles; the outputs depend combinationally on pc and state.
- **Update latency**: state written at the edge ending the upd_valid cycle, and visible to lookups in the following cycle.
- **Same-cycle read/write**: if lookup and update hit the same index in one cycle, the lookup returns the pre-update value. There is no write-through bypass.
- **Reset mid-update**: an asynchronous RST assertion discards the pending update. No partial write survives.
- BTB tag/target arrays are not reset; only the valid bits are.

## Test plan
- **Reset defaults**: RST low, pc=0x40 → pred_taken=0, pred_hit=0, pred_target=0x44; both stats 0.
- **Bimodal training** (HIST_EN=0): three updates, pc=0x20, taken, target 0x80.
  - After the 1st: counter=10, pred_taken=1, pred_target=0x80.
  - After the 2nd and 3rd: counter saturates at 11.
  - Then four not-taken updates → counter reaches 00 and stays there.
- **Tag alias**: train pc=0x20 taken, then look up pc=0x20+4·ENTRIES (same index, different tag) → pred_hit=0, pred_target=pc+4.
- **Gshare separation** (HIST_EN=1): same pc=0x100 trained taken with upd_ghr=0000 and not-taken with upd_ghr=0001.
  - Lookup with ghr=0000 predicts taken.
  - Lookup with ghr=0001 predicts not-taken.
- **Same-cycle and invalidate priority**:
  - Update and lookup of the same index in one cycle → lookup shows the old state; the new state appears next cycle.
  - btb_inv together with a taken update → entry is invalid afterwards.
- **Statistics**:
  - 5 updates, 2 of them with upd_pred_taken≠upd_taken → stat_branches=5, stat_mispredicts=2.
  - stat_clr together with upd_valid → both counters are 0.
